// File: rtl/apb_fifo_slave_pkg.sv
// rtl/apb_fifo_slave_pkg.sv - register map, control bits and FSM states for the APB FIFO slave
package apb_fifo_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    localparam int CTRL_DRAIN_EN    = 0;
    localparam int CTRL_FLUSH       = 1;
    localparam int STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_fifo_slave_if.sv
// rtl/apb_fifo_slave_if.sv - APB completer bus plus drain stream and interrupt
interface apb_fifo_slave_if #(
    parameter int ADD_WIDTH = 9,
    parameter int WIDTH     = 32
);
    logic                   Psel;
    logic                   Penable;
    logic                   Pwrite;
    logic [WIDTH/8-1:0]     Pstrb;
    logic [ADD_WIDTH-2:0]   Paddr;
    logic [WIDTH-1:0]       Pwdata;
    logic [WIDTH-1:0]       Prdata;
    logic                   Pready;
    logic                   Pslverr;
    logic                   m_valid;
    logic [WIDTH-1:0]       m_data;
    logic                   m_ready;
    logic                   irq;

    modport master (
        output Psel, Penable, Pwrite, Pstrb, Paddr, Pwdata, m_ready,
        input  Prdata, Pready, Pslverr, m_valid, m_data, irq
    );

    modport slave (
        input  Psel, Penable, Pwrite, Pstrb, Paddr, Pwdata, m_ready,
        output Prdata, Pready, Pslverr, m_valid, m_data, irq
    );
endinterface

// File: rtl/apb_fifo_slave_sync_fifo.sv
// rtl/apb_fifo_slave_sync_fifo.sv - first-word fall-through FIFO with extra-bit pointers
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/apb_fifo_slave.sv
// rtl/apb_fifo_slave.sv - APB completer pushing register writes into a FIFO drained by a valid/ready stream
module apb_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int ADD_WIDTH   = 9,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             pclk,
    input  logic             preset,
    apb_fifo_slave_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    apb_state_e       state_q;
    logic [3:0]       wait_cnt_q;
    logic             pready_q, pslverr_q;
    logic [WIDTH-1:0] prdata_q;
    logic             drain_en_q;
    logic [CW-1:0]    thresh_q, thresh_d;
    logic             irq_q, irq_d;
    logic [CW-1:0]    count, count_d;
    logic             full, empty;
    logic [WIDTH-1:0] head;
    logic [1:0]       sel;
    logic             out_of_range, setup_seen, err_c;
    logic             commit, push, pop, ctrl_wr, flush, m_valid;
    logic [WIDTH-1:0] rdata_c;
    logic             unused_bits;

    assign sel          = bus.Paddr[3:2];
    assign out_of_range = |bus.Paddr[ADD_WIDTH-2:4];
    assign setup_seen   = bus.Psel & ~bus.Penable;
    assign unused_bits  = ^{bus.Paddr[1:0], bus.Pwdata[WIDTH-1:CW]};

    // Out-of-range reads complete cleanly with zero data; only writes there are errors.
    always_comb begin
        err_c = 1'b0;
        if (bus.Pwrite) begin
            if (out_of_range)             err_c = 1'b1;
            else if (sel == ADDR_STATUS)  err_c = 1'b1;
            else if (sel == ADDR_DATA)    err_c = (bus.Pstrb != '1) || full;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (!bus.Pwrite && !out_of_range) begin
            case (sel)
                ADDR_STATUS: begin
                    rdata_c[STATUS_COUNT_LSB +: CW] = count;
                    rdata_c[1]                      = full;
                    rdata_c[0]                      = empty;
                end
                ADDR_CTRL:   rdata_c[CTRL_DRAIN_EN] = drain_en_q;
                ADDR_THRESH: rdata_c[CW-1:0]        = thresh_q;
                default:     rdata_c                = '0;
            endcase
        end
    end

    // The error decision is latched on entry to ACCESS, so commit obeys it even if a pop lands in between.
    assign commit  = (state_q == ACCESS) & bus.Psel & bus.Penable & bus.Pwrite & ~pslverr_q;
    assign push    = commit & (sel == ADDR_DATA);
    assign ctrl_wr = commit & (sel == ADDR_CTRL);
    assign flush   = ctrl_wr & bus.Pwdata[CTRL_FLUSH];
    assign m_valid = drain_en_q & ~empty;
    assign pop     = m_valid & bus.m_ready & ~flush;

    always_comb begin
        count_d = count;
        if (flush)              count_d = '0;
        else if (push && !pop)  count_d = count + 1'b1;
        else if (pop && !push)  count_d = count - 1'b1;
        thresh_d = (commit && sel == ADDR_THRESH) ? bus.Pwdata[CW-1:0] : thresh_q;
        irq_d    = (thresh_d != '0) && (count_d >= thresh_d);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            drain_en_q <= 1'b0;
            thresh_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCESS: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                    state_q   <= IDLE;
                    if (setup_seen) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= ACCESS;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_c;
                            prdata_q  <= rdata_c;
                        end else begin
                            state_q    <= SETUP;
                            wait_cnt_q <= WAIT_INIT;
                        end
                    end
                end
                SETUP, WAIT: begin
                    if (!bus.Psel) begin
                        state_q <= IDLE;
                    end else if (wait_cnt_q == 4'd0) begin
                        state_q   <= ACCESS;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_c;
                        prdata_q  <= rdata_c;
                    end else begin
                        state_q    <= WAIT;
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (ctrl_wr) drain_en_q <= bus.Pwdata[CTRL_DRAIN_EN];
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (push),
        .wdata (bus.Pwdata),
        .pop   (pop),
        .flush (flush),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    assign bus.Pready  = pready_q;
    assign bus.Pslverr = pslverr_q;
    assign bus.Prdata  = prdata_q;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_valid ? head : '0;
    assign bus.irq     = irq_q;
endmodule

// File: tb/tb_apb_fifo_slave.sv
// tb/tb_apb_fifo_slave.sv - directed table and sequence checks for apb_fifo_slave
module tb_apb_fifo_slave;
    logic pclk = 1'b0;
    logic preset;
    int   checks = 0;
    int   errors = 0;

    always #5 pclk = ~pclk;

    apb_fifo_slave_if #(.ADD_WIDTH(9), .WIDTH(32)) bus1 ();
    apb_fifo_slave_if #(.ADD_WIDTH(9), .WIDTH(32)) bus3 ();

    apb_fifo_slave #(.ADD_WIDTH(9), .WIDTH(32), .DEPTH(8), .WAIT_CYCLES(1)) u_dut1 (
        .pclk(pclk), .preset(preset), .bus(bus1)
    );
    apb_fifo_slave #(.ADD_WIDTH(9), .WIDTH(32), .DEPTH(8), .WAIT_CYCLES(3)) u_dut3 (
        .pclk(pclk), .preset(preset), .bus(bus3)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer1(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input bit pop_at_ready,
                         output logic [31:0] rdata, output logic err, output int lat);
        @(posedge pclk); #1;
        bus1.Psel = 1'b1; bus1.Penable = 1'b0; bus1.Pwrite = wr;
        bus1.Paddr = addr; bus1.Pwdata = wdata; bus1.Pstrb = strb;
        @(posedge pclk); #1;
        bus1.Penable = 1'b1;
        lat = 1;
        while (!bus1.Pready && lat < 20) begin
            @(posedge pclk); #1;
            lat++;
        end
        chk("pready_seen", bus1.Pready, 1'b1);
        rdata = bus1.Prdata;
        err   = bus1.Pslverr;
        if (pop_at_ready) bus1.m_ready = 1'b1;
        @(posedge pclk); #1;
        bus1.Psel = 1'b0; bus1.Penable = 1'b0; bus1.Pwrite = 1'b0;
        if (pop_at_ready) bus1.m_ready = 1'b0;
    endtask

    task automatic xfer3(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        @(posedge pclk); #1;
        bus3.Psel = 1'b1; bus3.Penable = 1'b0; bus3.Pwrite = wr;
        bus3.Paddr = addr; bus3.Pwdata = wdata; bus3.Pstrb = 4'hF;
        @(posedge pclk); #1;
        bus3.Penable = 1'b1;
        lat = 1;
        while (!bus3.Pready && lat < 20) begin
            @(posedge pclk); #1;
            lat++;
        end
        chk("pready3_seen", bus3.Pready, 1'b1);
        rdata = bus3.Prdata;
        err   = bus3.Pslverr;
        @(posedge pclk); #1;
        bus3.Psel = 1'b0; bus3.Penable = 1'b0; bus3.Pwrite = 1'b0;
    endtask

    task automatic wr1(input string name, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
        logic [31:0] r; logic e; int l;
        xfer1(1'b1, a, d, 4'hF, 1'b0, r, e, l);
        chk($sformatf("%s_err", name), e, exp_err);
    endtask

    task automatic rd1(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r; logic e; int l;
        xfer1(1'b0, a, 32'h0, 4'h0, 1'b0, r, e, l);
        chk($sformatf("%s_rdata", name), r, exp);
        chk($sformatf("%s_err", name), e, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          l;
        bit          saw;

        vt[0]  = '{1'b1, 8'h00, 32'hA5A5_0001, 4'hF, 32'h0000_0000, 1'b0};
        vt[1]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_0100, 1'b0};
        vt[2]  = '{1'b1, 8'h04, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
        vt[3]  = '{1'b1, 8'h10, 32'h1111_1111, 4'hF, 32'h0000_0000, 1'b1};
        vt[4]  = '{1'b1, 8'h00, 32'h0000_1234, 4'h7, 32'h0000_0000, 1'b1};
        vt[5]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_0100, 1'b0};
        vt[6]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vt[7]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vt[8]  = '{1'b1, 8'h0C, 32'hFFFF_FFF3, 4'hF, 32'h0000_0000, 1'b0};
        vt[9]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'h0000_0003, 1'b0};
        vt[10] = '{1'b1, 8'h08, 32'h0000_0002, 4'hF, 32'h0000_0000, 1'b0};
        vt[11] = '{1'b0, 8'h08, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vt[12] = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0000_0001, 1'b0};
        vt[13] = '{1'b1, 8'h0C, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};

        bus1.Psel = 0; bus1.Penable = 0; bus1.Pwrite = 0; bus1.Pstrb = 0;
        bus1.Paddr = 0; bus1.Pwdata = 0; bus1.m_ready = 0;
        bus3.Psel = 0; bus3.Penable = 0; bus3.Pwrite = 0; bus3.Pstrb = 0;
        bus3.Paddr = 0; bus3.Pwdata = 0; bus3.m_ready = 0;
        preset = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready",  bus1.Pready,  1'b0);
        chk("rst_pslverr", bus1.Pslverr, 1'b0);
        chk("rst_prdata",  bus1.Prdata,  32'h0);
        chk("rst_m_valid", bus1.m_valid, 1'b0);
        chk("rst_m_data",  bus1.m_data,  32'h0);
        chk("rst_irq",     bus1.irq,     1'b0);
        preset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xfer1(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, 1'b0, r, e, l);
            chk($sformatf("vec%0d_err", i), e, vt[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), r, vt[i].exp_rdata);
            chk($sformatf("vec%0d_latency", i), l, 2);
            chk($sformatf("vec%0d_pready_drop", i), bus1.Pready, 1'b0);
        end

        for (int i = 0; i < 8; i++) wr1($sformatf("fill%0d", i), 8'h00, 32'h1000_0000 + i, 1'b0);
        rd1("status_full", 8'h04, 32'h0000_0802);
        wr1("overflow", 8'h00, 32'hDEAD_BEEF, 1'b1);
        rd1("status_after_overflow", 8'h04, 32'h0000_0802);
        chk("no_drain_m_valid", bus1.m_valid, 1'b0);

        wr1("drain_on", 8'h08, 32'h1, 1'b0);
        chk("full_head_valid", bus1.m_valid, 1'b1);
        chk("full_head_data", bus1.m_data, 32'h1000_0000);
        xfer1(1'b1, 8'h00, 32'h0000_0BAD, 4'hF, 1'b1, r, e, l);
        chk("full_push_with_pop_err", e, 1'b1);
        chk("head_after_pop", bus1.m_data, 32'h1000_0001);
        rd1("status_count7", 8'h04, 32'h0000_0700);
        xfer1(1'b1, 8'h08, 32'h0000_0003, 4'hF, 1'b1, r, e, l);
        chk("flush_err", e, 1'b0);
        rd1("status_flushed", 8'h04, 32'h0000_0001);
        rd1("ctrl_after_flush", 8'h08, 32'h0000_0001);
        chk("flushed_m_valid", bus1.m_valid, 1'b0);

        wr1("drain_off", 8'h08, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) wr1($sformatf("burst%0d", i), 8'h00, 32'h2000_0000 + i, 1'b0);
        bus1.m_ready = 1'b1;
        wr1("drain_on2", 8'h08, 32'h1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), bus1.m_valid, 1'b1);
            chk($sformatf("drain%0d_data", i), bus1.m_data, 32'h2000_0000 + i);
            @(posedge pclk); #1;
        end
        chk("drain_done_valid", bus1.m_valid, 1'b0);
        bus1.m_ready = 1'b0;
        rd1("status_drained", 8'h04, 32'h0000_0001);

        wr1("irq_drain_off", 8'h08, 32'h0, 1'b0);
        wr1("irq_thresh", 8'h0C, 32'h3, 1'b0);
        chk("irq_empty", bus1.irq, 1'b0);
        wr1("irq_push0", 8'h00, 32'h30, 1'b0);
        wr1("irq_push1", 8'h00, 32'h31, 1'b0);
        chk("irq_below", bus1.irq, 1'b0);
        wr1("irq_push2", 8'h00, 32'h32, 1'b0);
        chk("irq_rise", bus1.irq, 1'b1);
        rd1("irq_status", 8'h04, 32'h0000_0300);
        wr1("irq_drain_on", 8'h08, 32'h1, 1'b0);
        chk("irq_head", bus1.m_data, 32'h30);
        bus1.m_ready = 1'b1;
        @(posedge pclk); #1;
        bus1.m_ready = 1'b0;
        chk("irq_fall", bus1.irq, 1'b0);
        chk("irq_next_head", bus1.m_data, 32'h31);

        bus1.m_ready = 1'b1;
        preset = 1'b1;
        @(posedge pclk); #1;
        chk("mid_rst_pready",  bus1.Pready,  1'b0);
        chk("mid_rst_pslverr", bus1.Pslverr, 1'b0);
        chk("mid_rst_prdata",  bus1.Prdata,  32'h0);
        chk("mid_rst_m_valid", bus1.m_valid, 1'b0);
        chk("mid_rst_m_data",  bus1.m_data,  32'h0);
        chk("mid_rst_irq",     bus1.irq,     1'b0);
        preset = 1'b0;
        bus1.m_ready = 1'b0;
        rd1("rst_status", 8'h04, 32'h0000_0001);
        rd1("rst_ctrl", 8'h08, 32'h0);
        rd1("rst_thresh", 8'h0C, 32'h0);

        xfer3(1'b1, 8'h00, 32'hCAFE_0001, r, e, l);
        chk("w3_err", e, 1'b0);
        chk("w3_latency", l, 4);
        @(posedge pclk); #1;
        bus3.Psel = 1'b1; bus3.Penable = 1'b0; bus3.Pwrite = 1'b1;
        bus3.Paddr = 8'h00; bus3.Pwdata = 32'hDEAD_0000; bus3.Pstrb = 4'hF;
        saw = 1'b0;
        @(posedge pclk); #1;
        bus3.Penable = 1'b1;
        saw |= bus3.Pready;
        @(posedge pclk); #1;
        saw |= bus3.Pready;
        bus3.Psel = 1'b0; bus3.Penable = 1'b0; bus3.Pwrite = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            saw |= bus3.Pready;
        end
        chk("w3_drop_no_pready", saw, 1'b0);
        xfer3(1'b0, 8'h04, 32'h0, r, e, l);
        chk("w3_status_rdata", r, 32'h0000_0100);
        chk("w3_status_latency", l, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
